kv_refill_alloc: RTL and testbench
==================================

KV_REFILL_ALLOC -- requirements
Module: kv_refill_alloc

Interface
REQ-001 SHALL have parameter WAY_NUM, default 4, meaning number of cache ways (power of 2, 2..8).
REQ-002 SHALL have parameter IDX_W, default 6, meaning set-index width.
REQ-003 SHALL have parameter TAG_W, default 20, meaning tag width.
REQ-004 SHALL have parameter LINE_BEATS, default 4, meaning data beats per line (power of 2, >=2).
REQ-005 SHALL have parameter DATA_W, default 32, meaning beat width.
REQ-006 SHALL have ports, clock and reset first: i_clk in 1 clock; i_rst_n in 1 synchronous active-low reset.
REQ-007 SHALL have miss-request ports: i_miss_valid in 1; o_miss_ready out 1; i_miss_index in IDX_W; i_miss_tag in TAG_W; i_valid_way in WAY_NUM, valid bits of the indexed set.
REQ-008 SHALL have memory-request ports: o_mem_req_valid out 1; i_mem_req_ready in 1; o_mem_req_addr out TAG_W+IDX_W, line address {tag,index}.
REQ-009 SHALL have memory-response ports: i_mem_rsp_valid in 1; i_mem_rsp_data in DATA_W (always accepted, no ready).
REQ-010 SHALL have cache-write ports: o_wr_en out 1; o_wr_way out WAY_NUM one-hot; o_wr_index out IDX_W; o_wr_beat out log2(LINE_BEATS); o_wr_data out DATA_W.
REQ-011 SHALL have commit ports: o_tag_wr_en out 1; o_tag_wr_tag out TAG_W; o_done out 1, single-cycle pulse.

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> FILL -> COMMIT -> IDLE.
REQ-013 SHALL drive o_miss_ready=1 only in IDLE; request accepted when i_miss_valid && o_miss_ready; index, tag and victim latched that cycle.
REQ-014 SHALL select victim as the killmask (one-hot lowest-index invalid way) when i_valid_way != all-ones.
REQ-015 SHALL, when i_valid_way is all-ones, select victim one-hot from the replacement pointer, and advance the pointer by one (wrapping WAY_NUM-1 -> 0) only in that case.
REQ-016 SHALL hold o_mem_req_valid=1 with stable o_mem_req_addr throughout REQ; transition to FILL on the cycle after i_mem_req_ready is sampled high.
REQ-017 SHALL, in FILL, on each i_mem_rsp_valid, register one write: o_wr_en=1 next cycle with latched way/index, o_wr_beat = beat counter, o_wr_data = beat data; counter increments, beats 0..LINE_BEATS-1 in order.
REQ-018 SHALL enter COMMIT on acceptance of beat LINE_BEATS-1; in COMMIT assert o_tag_wr_en, o_tag_wr_tag = latched tag, o_done for exactly one cycle, then IDLE.
REQ-019 SHALL ignore i_mem_rsp_valid in IDLE, REQ and COMMIT (no write, no counter change).
REQ-020 SHALL keep o_wr_en low except the cycle after an accepted FILL beat; back-to-back beats yield back-to-back writes.
REQ-021 SHALL keep o_mem_req_valid, o_tag_wr_en and o_done low outside REQ and COMMIT respectively.

Reset
REQ-022 SHALL, with i_rst_n low at a rising edge, enter IDLE, clear beat counter and replacement pointer, and drive all valid/enable/done outputs 0 and data outputs 0.
REQ-023 SHALL, on reset mid-REQ or mid-FILL, abandon the refill with no tag write and no o_done.

Configuration
REQ-024 SHALL, with KV_REFILL_LFSR_EN defined, replace the round-robin pointer with an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'h01) advanced only when a full-set victim is taken, victim index = low log2(WAY_NUM) bits.
REQ-025 SHALL, without KV_REFILL_LFSR_EN, use the round-robin pointer of REQ-015.

Structure
REQ-026 SHALL place the FSM state enum and the LFSR seed/tap constants in shared package kv_cache_pkg.
REQ-027 SHALL instantiate KVSelectInvalidWay (WAY_NUM passed through) as its sole sub-module to produce the killmask.

Verification
REQ-028 SHALL cover: i_valid_way=4'b1011, index 5, tag 0x12345 -> o_wr_way=4'b0100, o_mem_req_addr={0x12345,6'd5}, 4 writes beats 0..3, o_done once.
REQ-029 SHALL cover: three misses with i_valid_way=4'b1111 (no LFSR) -> victims 4'b0001, 4'b0010, 4'b0100; fourth -> 4'b1000, fifth wraps to 4'b0001.
REQ-030 SHALL cover: i_mem_req_ready low for 5 cycles -> o_mem_req_valid held 5+ cycles, address stable, no writes.
REQ-031 SHALL cover: i_mem_rsp_valid pulsed while IDLE -> o_wr_en stays 0; gapped beats (1,0,1,1,0,1) -> exactly 4 writes, beats in order.
REQ-032 SHALL cover: reset asserted after beat 1 -> no o_tag_wr_en, no o_done, o_miss_ready=1 after reset; next miss with 4'b1111 picks 4'b0001.
REQ-033 SHALL cover: with KV_REFILL_LFSR_EN, two full-set misses -> victims follow LFSR sequence from seed 8'h01.

Source files
------------

// File: rtl/kv_cache_pkg.sv
// Shared refill-allocator types and victim-LFSR constants.
package kv_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } refill_state_e;

    // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (feedback bits 7,5,4,3)
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        lfsr_step = {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/KVSelectInvalidWay.sv
// One-hot mask of the lowest-index invalid way; all zeros when every way is valid.
module KVSelectInvalidWay #(
    parameter int WAY_NUM = 4
) (
    input  logic [WAY_NUM-1:0] valid_way,
    output logic [WAY_NUM-1:0] kill_mask
);

    logic [WAY_NUM-1:0] invalid_s;

    // Isolate the lowest set bit of the invalid vector (x & -x)
    always_comb begin
        invalid_s = ~valid_way;
        kill_mask = invalid_s & (~invalid_s + WAY_NUM'(1'b1));
    end

endmodule

// File: rtl/kv_refill_alloc.sv
// Cache-miss refill allocator: victim select, line request, beat fill, tag commit.
// Build option: KV_REFILL_LFSR_EN swaps the round-robin full-set pointer for an 8-bit LFSR.
module kv_refill_alloc
    import kv_cache_pkg::*;
#(
    parameter int WAY_NUM    = 4,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 20,
    parameter int LINE_BEATS = 4,
    parameter int DATA_W     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_miss_valid,
    output logic                          o_miss_ready,
    input  logic [IDX_W-1:0]              i_miss_index,
    input  logic [TAG_W-1:0]              i_miss_tag,
    input  logic [WAY_NUM-1:0]            i_valid_way,
    output logic                          o_mem_req_valid,
    input  logic                          i_mem_req_ready,
    output logic [TAG_W+IDX_W-1:0]        o_mem_req_addr,
    input  logic                          i_mem_rsp_valid,
    input  logic [DATA_W-1:0]             i_mem_rsp_data,
    output logic                          o_wr_en,
    output logic [WAY_NUM-1:0]            o_wr_way,
    output logic [IDX_W-1:0]              o_wr_index,
    output logic [$clog2(LINE_BEATS)-1:0] o_wr_beat,
    output logic [DATA_W-1:0]             o_wr_data,
    output logic                          o_tag_wr_en,
    output logic [TAG_W-1:0]              o_tag_wr_tag,
    output logic                          o_done
);

    localparam int WAY_IDX_W = $clog2(WAY_NUM);
    localparam int BEAT_W    = $clog2(LINE_BEATS);
    localparam logic [WAY_NUM-1:0] WAY_ONE   = WAY_NUM'(1'b1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(LINE_BEATS - 1);

    refill_state_e        state_r, state_nx_s;
    logic [IDX_W-1:0]     index_r;
    logic [TAG_W-1:0]     tag_r;
    logic [WAY_NUM-1:0]   victim_r, victim_s, kill_mask_s;
    logic [BEAT_W-1:0]    beat_cnt_r;
    logic [WAY_IDX_W-1:0] repl_idx_s;
    logic                 full_set_s, accept_s, rsp_take_s;
    logic                 miss_ready_r, mem_req_valid_r, tag_wr_en_r, done_r;
    logic                 wr_en_r;
    logic [WAY_NUM-1:0]   wr_way_r;
    logic [IDX_W-1:0]     wr_index_r;
    logic [BEAT_W-1:0]    wr_beat_r;
    logic [DATA_W-1:0]    wr_data_r;

`ifdef KV_REFILL_LFSR_EN
    logic [7:0]           repl_r, repl_nx_s, repl_seed_s;
`else
    logic [WAY_IDX_W-1:0] repl_r, repl_nx_s, repl_seed_s;
`endif

    KVSelectInvalidWay #(.WAY_NUM(WAY_NUM)) u_kill (
        .valid_way (i_valid_way),
        .kill_mask (kill_mask_s)
    );

    // Replacement-pointer decode and advance; only consumed when the set is full
    always_comb begin
`ifdef KV_REFILL_LFSR_EN
        repl_seed_s = LFSR_SEED;
        repl_idx_s  = repl_r[WAY_IDX_W-1:0];
        repl_nx_s   = lfsr_step(repl_r);
`else
        repl_seed_s = '0;
        repl_idx_s  = repl_r;
        repl_nx_s   = repl_r + WAY_IDX_W'(1'b1);
`endif
    end

    // Victim choice plus handshake qualifiers
    always_comb begin
        full_set_s = &i_valid_way;
        accept_s   = i_miss_valid && (state_r == ST_IDLE);
        rsp_take_s = i_mem_rsp_valid && (state_r == ST_FILL);
        if (full_set_s) begin
            victim_s = WAY_ONE << repl_idx_s;
        end else begin
            victim_s = kill_mask_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_miss_valid) state_nx_s = ST_REQ;
                else              state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (i_mem_req_ready) state_nx_s = ST_FILL;
                else                 state_nx_s = ST_REQ;
            end
            ST_FILL: begin
                if (rsp_take_s && (beat_cnt_r == BEAT_LAST)) state_nx_s = ST_COMMIT;
                else                                         state_nx_s = ST_FILL;
            end
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State, request latches and registered outputs (status flags follow next state)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r         <= ST_IDLE;
            index_r         <= '0;
            tag_r           <= '0;
            victim_r        <= '0;
            beat_cnt_r      <= '0;
            repl_r          <= repl_seed_s;
            miss_ready_r    <= 1'b1;
            mem_req_valid_r <= 1'b0;
            tag_wr_en_r     <= 1'b0;
            done_r          <= 1'b0;
            wr_en_r         <= 1'b0;
            wr_way_r        <= '0;
            wr_index_r      <= '0;
            wr_beat_r       <= '0;
            wr_data_r       <= '0;
        end else begin
            state_r         <= state_nx_s;
            miss_ready_r    <= (state_nx_s == ST_IDLE);
            mem_req_valid_r <= (state_nx_s == ST_REQ);
            tag_wr_en_r     <= (state_nx_s == ST_COMMIT);
            done_r          <= (state_nx_s == ST_COMMIT);
            wr_en_r         <= rsp_take_s;
            if (accept_s) begin
                index_r    <= i_miss_index;
                tag_r      <= i_miss_tag;
                victim_r   <= victim_s;
                beat_cnt_r <= '0;
                if (full_set_s) repl_r <= repl_nx_s;
            end
            if (rsp_take_s) begin
                wr_way_r   <= victim_r;
                wr_index_r <= index_r;
                wr_beat_r  <= beat_cnt_r;
                wr_data_r  <= i_mem_rsp_data;
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1'b1);
            end
        end
    end

    assign o_miss_ready    = miss_ready_r;
    assign o_mem_req_valid = mem_req_valid_r;
    assign o_mem_req_addr  = {tag_r, index_r};
    assign o_wr_en         = wr_en_r;
    assign o_wr_way        = wr_way_r;
    assign o_wr_index      = wr_index_r;
    assign o_wr_beat       = wr_beat_r;
    assign o_wr_data       = wr_data_r;
    assign o_tag_wr_en     = tag_wr_en_r;
    assign o_tag_wr_tag    = tag_r;
    assign o_done          = done_r;

endmodule

// File: tb/tb_kv_refill_alloc.sv
// Directed bench for kv_refill_alloc: table of refills plus reset/idle corner sequences.
module tb_kv_refill_alloc;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_miss_valid;
    logic        o_miss_ready;
    logic [5:0]  i_miss_index;
    logic [19:0] i_miss_tag;
    logic [3:0]  i_valid_way;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [25:0] o_mem_req_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_wr_en;
    logic [3:0]  o_wr_way;
    logic [5:0]  o_wr_index;
    logic [1:0]  o_wr_beat;
    logic [31:0] o_wr_data;
    logic        o_tag_wr_en;
    logic [19:0] o_tag_wr_tag;
    logic        o_done;

    kv_refill_alloc dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_miss_valid    (i_miss_valid),
        .o_miss_ready    (o_miss_ready),
        .i_miss_index    (i_miss_index),
        .i_miss_tag      (i_miss_tag),
        .i_valid_way     (i_valid_way),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_wr_en         (o_wr_en),
        .o_wr_way        (o_wr_way),
        .o_wr_index      (o_wr_index),
        .o_wr_beat       (o_wr_beat),
        .o_wr_data       (o_wr_data),
        .o_tag_wr_en     (o_tag_wr_en),
        .o_tag_wr_tag    (o_tag_wr_tag),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  vw;
        logic [5:0]  idx;
        logic [19:0] tag;
        logic [3:0]  exp_way;
        int          rdy_wait;
        logic [7:0]  gap;
        int          gap_len;
    } vec_t;

    vec_t vecs[8];
    vec_t post_rst;

    int total = 0;
    int bad   = 0;
    int wr_cnt, tag_cnt, done_cnt, exp_beat;
    logic [3:0]  exp_way_m;
    logic [5:0]  exp_idx_m;
    logic [19:0] exp_tag_m;
    logic [3:0]  rst_way;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Write/commit observer on the inactive edge
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            chk("wr_beat",  64'(o_wr_beat),  64'(exp_beat));
            chk("wr_way",   64'(o_wr_way),   64'(exp_way_m));
            chk("wr_index", 64'(o_wr_index), 64'(exp_idx_m));
            chk("wr_data",  64'(o_wr_data),  64'(32'hD000_0000 | 32'(exp_beat)));
            exp_beat++;
            wr_cnt++;
        end
        if (o_tag_wr_en) begin
            tag_cnt++;
            chk("tag_wr_tag", 64'(o_tag_wr_tag), 64'(exp_tag_m));
        end
        if (o_done) done_cnt++;
    end

    task automatic clear_obs(input logic [3:0] way, input logic [5:0] idx, input logic [19:0] tag);
        exp_way_m = way;
        exp_idx_m = idx;
        exp_tag_m = tag;
        exp_beat  = 0;
        wr_cnt    = 0;
        tag_cnt   = 0;
        done_cnt  = 0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_refill(input vec_t v);
        logic [25:0] exp_addr;
        int sent;
        int k;
        exp_addr = {v.tag, v.idx};
        chk("miss_ready_idle", 64'(o_miss_ready), 64'd1);
        clear_obs(v.exp_way, v.idx, v.tag);
        i_miss_valid = 1'b1;
        i_miss_index = v.idx;
        i_miss_tag   = v.tag;
        i_valid_way  = v.vw;
        step();
        i_miss_valid = 1'b0;
        i_valid_way  = 4'b0000;
        i_miss_tag   = 20'h0;
        chk("req_valid",       64'(o_mem_req_valid), 64'd1);
        chk("miss_ready_busy", 64'(o_miss_ready),    64'd0);
        chk("req_addr",        64'(o_mem_req_addr),  64'(exp_addr));
        for (int c = 0; c < v.rdy_wait; c++) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = 32'hBAD0_0000;
            step();
            chk("req_hold_valid", 64'(o_mem_req_valid), 64'd1);
            chk("req_hold_addr",  64'(o_mem_req_addr),  64'(exp_addr));
        end
        i_mem_rsp_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        chk("req_no_wr", 64'(wr_cnt),          64'd0);
        chk("req_drop",  64'(o_mem_req_valid), 64'd0);
        sent = 0;
        k    = 0;
        while (sent < 4 && k < 64) begin
            i_mem_rsp_valid = v.gap[k % v.gap_len];
            i_mem_rsp_data  = 32'hD000_0000 | 32'(sent);
            if (i_mem_rsp_valid) sent++;
            step();
            k++;
        end
        i_mem_rsp_valid = 1'b0;
        chk("commit_tag_en", 64'(o_tag_wr_en), 64'd1);
        chk("commit_done",   64'(o_done),      64'd1);
        step();
        chk("done_pulse_len", 64'(o_done), 64'd0);
        step();
        chk("wr_count",   64'(wr_cnt),       64'd4);
        chk("done_count", 64'(done_cnt),     64'd1);
        chk("tag_count",  64'(tag_cnt),      64'd1);
        chk("back_idle",  64'(o_miss_ready), 64'd1);
    endtask

    initial begin
`ifdef KV_REFILL_LFSR_EN
        // LFSR from seed 01: 01 -> 02 -> 04 -> 08 -> 11 -> 23; victim = low two bits
        vecs[0] = '{4'b1011, 6'd5,  20'h12345, 4'b0100, 0, 8'h01, 1};
        vecs[1] = '{4'b1111, 6'd1,  20'h00001, 4'b0010, 0, 8'h01, 1};
        vecs[2] = '{4'b1111, 6'd2,  20'h00002, 4'b0100, 5, 8'h01, 1};
        vecs[3] = '{4'b0000, 6'd3,  20'hFFFFF, 4'b0001, 0, 8'h2D, 6};
        vecs[4] = '{4'b1111, 6'd63, 20'h55555, 4'b0001, 1, 8'h01, 1};
        vecs[5] = '{4'b1111, 6'd0,  20'hAAAAA, 4'b0001, 0, 8'h05, 3};
        vecs[6] = '{4'b1111, 6'd7,  20'h0F0F0, 4'b0010, 0, 8'h01, 1};
        vecs[7] = '{4'b0111, 6'd8,  20'h00808, 4'b1000, 0, 8'h01, 1};
        rst_way  = 4'b1000;
        post_rst = '{4'b1111, 6'd11, 20'h13579, 4'b0010, 0, 8'h01, 1};
`else
        vecs[0] = '{4'b1011, 6'd5,  20'h12345, 4'b0100, 0, 8'h01, 1};
        vecs[1] = '{4'b1111, 6'd1,  20'h00001, 4'b0001, 0, 8'h01, 1};
        vecs[2] = '{4'b1111, 6'd2,  20'h00002, 4'b0010, 5, 8'h01, 1};
        vecs[3] = '{4'b0000, 6'd3,  20'hFFFFF, 4'b0001, 0, 8'h2D, 6};
        vecs[4] = '{4'b1111, 6'd63, 20'h55555, 4'b0100, 1, 8'h01, 1};
        vecs[5] = '{4'b1111, 6'd0,  20'hAAAAA, 4'b1000, 0, 8'h05, 3};
        vecs[6] = '{4'b1111, 6'd7,  20'h0F0F0, 4'b0001, 0, 8'h01, 1};
        vecs[7] = '{4'b0111, 6'd8,  20'h00808, 4'b1000, 0, 8'h01, 1};
        rst_way  = 4'b0010;
        post_rst = '{4'b1111, 6'd11, 20'h13579, 4'b0001, 0, 8'h01, 1};
`endif
        i_rst_n         = 1'b0;
        i_miss_valid    = 1'b0;
        i_miss_index    = 6'd0;
        i_miss_tag      = 20'h0;
        i_valid_way     = 4'b0000;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = 32'h0;
        clear_obs(4'b0000, 6'd0, 20'h0);
        step();
        step();
        chk("rst_miss_ready", 64'(o_miss_ready),    64'd1);
        chk("rst_req_valid",  64'(o_mem_req_valid), 64'd0);
        chk("rst_req_addr",   64'(o_mem_req_addr),  64'd0);
        chk("rst_wr_en",      64'(o_wr_en),         64'd0);
        chk("rst_wr_data",    64'(o_wr_data),       64'd0);
        chk("rst_tag_wr_en",  64'(o_tag_wr_en),     64'd0);
        chk("rst_done",       64'(o_done),          64'd0);
        i_rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_refill(vecs[i]);

        // Response beats while idle must not write
        clear_obs(4'b0000, 6'd0, 20'h0);
        for (int c = 0; c < 3; c++) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = 32'hBAD0_0001;
            step();
            chk("idle_rsp_no_wr", 64'(o_wr_en), 64'd0);
        end
        i_mem_rsp_valid = 1'b0;
        step();
        chk("idle_rsp_count", 64'(wr_cnt), 64'd0);

        // Reset after beat 1 abandons the refill
        clear_obs(rst_way, 6'd9, 20'hABCDE);
        i_miss_valid = 1'b1;
        i_miss_index = 6'd9;
        i_miss_tag   = 20'hABCDE;
        i_valid_way  = 4'b1111;
        step();
        i_miss_valid    = 1'b0;
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = 32'hD000_0000;
        step();
        i_mem_rsp_data  = 32'hD000_0001;
        step();
        i_mem_rsp_valid = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        chk("midfill_rst_ready", 64'(o_miss_ready),    64'd1);
        chk("midfill_rst_wr_en", 64'(o_wr_en),         64'd0);
        chk("midfill_rst_req",   64'(o_mem_req_valid), 64'd0);
        step();
        step();
        step();
        chk("midfill_wr_count",  64'(wr_cnt),   64'd2);
        chk("midfill_no_tag",    64'(tag_cnt),  64'd0);
        chk("midfill_no_done",   64'(done_cnt), 64'd0);

        run_refill(post_rst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
